// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback result select, 31x32 register file with write-through bypass and commit counter
module writeback_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] ReadDataW,
  input  logic [31:0] PCPlus4W,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] ResultW,
  output logic [31:0] WbCount
);

  // x0 is hardwired zero, so storage starts at index 1
  logic [31:0] regs_q [1:31];
  logic [31:0] wb_count_q;
  logic [31:0] wb_count_d;
  logic        commit;

  always_comb begin
    case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  assign commit     = RegWriteW && (RdW != 5'd0);
  assign wb_count_d = wb_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else if (commit) begin
      regs_q[RdW] <= ResultW;
      wb_count_q  <= wb_count_d;
    end
  end

  // The write port is forwarded so a same-cycle read sees the value being committed
  always_comb begin
    RD1 = '0;
    if (!rst && (A1 != 5'd0)) begin
      if (commit && (A1 == RdW)) RD1 = ResultW;
      else                       RD1 = regs_q[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (!rst && (A2 != 5'd0)) begin
      if (commit && (A2 == RdW)) RD2 = ResultW;
      else                       RD2 = regs_q[A2];
    end
  end

  assign WbCount = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - randomized and directed checks of writeback_regfile against a reference model
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW, A1, A2;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] RD1, RD2, ResultW, WbCount;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_regs [32];
  logic [31:0] ref_count;
  bit          ref_valid = 0;

  writeback_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .A1         (A1),
    .A2         (A2),
    .RD1        (RD1),
    .RD2        (RD2),
    .ResultW    (ResultW),
    .WbCount    (WbCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result();
    logic [31:0] srcs [4];
    srcs = '{ALUResultW, ReadDataW, PCPlus4W, ALUResultW};
    return srcs[ResultSrcW];
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (rst || a == 0) return 32'd0;
    if (RegWriteW && RdW != 0 && a == RdW) return ref_result();
    return ref_regs[a];
  endfunction

  // Compare all outputs against the model, away from the active edge
  task automatic sample();
    @(negedge clk);
    check("result", ResultW, ref_result());
    if (ref_valid || rst) begin
      check("rd1", RD1, ref_read(A1));
      check("rd2", RD2, ref_read(A2));
    end
    if (ref_valid) check("wbcount", WbCount, ref_count);
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      foreach (ref_regs[i]) ref_regs[i] = 32'd0;
      ref_count = 32'd0;
      ref_valid = 1;
    end else if (RegWriteW && RdW != 0) begin
      ref_regs[RdW] = ref_result();
      ref_count     = ref_count + 1;
    end
    #1;
  endtask

  task automatic step();
    sample();
    commit();
  endtask

  initial begin
    logic [31:0] mux_exp [4];
    foreach (ref_regs[i]) ref_regs[i] = 32'd0;
    ref_count  = 32'd0;
    rst        = 1'b1;
    ALUResultW = 32'd0;
    ReadDataW  = 32'd0;
    PCPlus4W   = 32'd0;
    RdW        = 5'd0;
    RegWriteW  = 1'b0;
    ResultSrcW = 2'b00;
    A1         = 5'd0;
    A2         = 5'd0;

    step();
    step();
    rst = 1'b0;
    A1  = 5'd5;
    A2  = 5'd31;
    sample();
    check("reset_rd1", RD1, 32'd0);
    check("reset_rd2", RD2, 32'd0);
    check("reset_count", WbCount, 32'd0);
    commit();

    ALUResultW = 32'h11;
    ReadDataW  = 32'h22;
    PCPlus4W   = 32'h33;
    mux_exp    = '{32'h11, 32'h22, 32'h33, 32'h11};
    for (int s = 0; s < 4; s++) begin
      ResultSrcW = s[1:0];
      sample();
      check("mux_sel", ResultW, mux_exp[s]);
      commit();
    end

    RegWriteW  = 1'b1;
    RdW        = 5'd7;
    ResultSrcW = 2'b01;
    ReadDataW  = 32'hDEADBEEF;
    step();
    RegWriteW  = 1'b0;
    A1         = 5'd7;
    sample();
    check("load_rd1", RD1, 32'hDEADBEEF);
    check("load_count", WbCount, 32'd1);
    commit();

    RegWriteW  = 1'b1;
    RdW        = 5'd3;
    ALUResultW = 32'hA5A5;
    ResultSrcW = 2'b00;
    A1         = 5'd3;
    A2         = 5'd3;
    sample();
    check("bypass_rd1", RD1, 32'hA5A5);
    check("bypass_rd2", RD2, 32'hA5A5);
    commit();

    RdW        = 5'd0;
    ALUResultW = 32'hFFFF;
    A1         = 5'd0;
    sample();
    check("x0_rd1_same", RD1, 32'd0);
    commit();
    RegWriteW  = 1'b0;
    sample();
    check("x0_rd1_next", RD1, 32'd0);
    check("x0_count", WbCount, 32'd2);
    commit();

    rst        = 1'b1;
    RegWriteW  = 1'b1;
    RdW        = 5'd9;
    ALUResultW = 32'h1234;
    A1         = 5'd9;
    sample();
    check("rst_rd1_suppressed", RD1, 32'd0);
    commit();
    rst        = 1'b0;
    RegWriteW  = 1'b0;
    sample();
    check("rstprio_rd1", RD1, 32'd0);
    check("rstprio_count", WbCount, 32'd0);
    commit();
    RegWriteW  = 1'b1;
    step();
    RegWriteW  = 1'b0;
    sample();
    check("post_rst_rd1", RD1, 32'h1234);
    check("post_rst_count", WbCount, 32'd1);
    commit();

    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) < 2);
      ALUResultW = $urandom;
      ReadDataW  = $urandom;
      PCPlus4W   = $urandom;
      ResultSrcW = 2'($urandom_range(0, 3));
      RegWriteW  = ($urandom_range(0, 3) != 0);
      RdW        = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      A1         = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
      A2         = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: ALUResultW  input  32  ALU result from MEM/WB pipeline register.
REQ-004 SHALL have port: ReadDataW  input  32  load data from MEM/WB pipeline register.
REQ-005 SHALL have port: PCPlus4W  input  32  link address from MEM/WB pipeline register.
REQ-006 SHALL have port: RdW  input  5  destination register index.
REQ-007 SHALL have port: RegWriteW  input  1  write enable for RdW.
REQ-008 SHALL have port: ResultSrcW  input  2  result select.
REQ-009 SHALL have port: A1  input  5  decode-stage read address, port 1.
REQ-010 SHALL have port: A2  input  5  decode-stage read address, port 2.
REQ-011 SHALL have port: RD1  output  32  read data, port 1.
REQ-012 SHALL have port: RD2  output  32  read data, port 2.
REQ-013 SHALL have port: ResultW  output  32  selected writeback value, for hazard-unit forwarding.
REQ-014 SHALL have port: WbCount  output  32  count of committed register writes.

Function
REQ-015 SHALL compute ResultW combinationally: 00 -> ALUResultW; 01 -> ReadDataW; 10 -> PCPlus4W; 11 (reserved) -> ALUResultW.
REQ-016 SHALL hold 31 architectural 32-bit registers x1..x31; x0 SHALL read 0 and SHALL NOT be stored.
REQ-017 SHALL commit on posedge clk when rst=0, RegWriteW=1 and RdW!=0: reg[RdW] <= ResultW.
REQ-018 SHALL ignore writes with RdW=0 or RegWriteW=0; no state changes in either case.
REQ-019 SHALL provide combinational reads: RD1 = (A1==0) ? 0 : reg[A1]; same for RD2/A2.
REQ-020 SHALL apply write-through bypass: if RegWriteW=1, RdW!=0 and A1==RdW, RD1 = ResultW in the same cycle; same for RD2/A2; both ports SHALL bypass independently and simultaneously.
REQ-021 SHALL increment WbCount by 1 on every committed write (REQ-017), 32-bit modulo: 0xFFFFFFFF wraps to 0x00000000.
REQ-022 SHALL NOT increment WbCount for ignored writes (REQ-018).
REQ-023 Read-to-write latency SHALL be 0 cycles via bypass; without bypass, written data SHALL be visible from the cycle after the commit edge.
REQ-024 Registers not addressed by a write SHALL retain their values indefinitely.

Reset
REQ-025 On posedge clk with rst=1: all x1..x31 <= 0 and WbCount <= 0.
REQ-026 rst SHALL take priority: a write presented in the same cycle as rst=1 SHALL be discarded and SHALL NOT be counted.
REQ-027 While rst=1: RD1=0 and RD2=0 (bypass suppressed); ResultW SHALL remain the combinational select of REQ-015.
REQ-028 Power-up state before the first reset is undefined; the bench SHALL assert rst for at least 1 cycle first.
REQ-029 A reset asserted mid-sequence SHALL clear all prior writes; the first post-reset write SHALL bring WbCount to 1.

Verification
REQ-030 Reset: rst=1 for 2 cycles, then A1=5, A2=31 -> RD1=0, RD2=0, WbCount=0.
REQ-031 Result mux: ALUResultW=0x11, ReadDataW=0x22, PCPlus4W=0x33; ResultSrcW=00/01/10/11 -> ResultW=0x11/0x22/0x33/0x11.
REQ-032 Write/read: RegWriteW=1, RdW=7, ResultSrcW=01, ReadDataW=0xDEADBEEF; next cycle RegWriteW=0, A1=7 -> RD1=0xDEADBEEF, WbCount=1.
REQ-033 Bypass: RegWriteW=1, RdW=3, ALUResultW=0xA5A5, ResultSrcW=00, A1=A2=3 in the same cycle -> RD1=RD2=0xA5A5 before the commit edge.
REQ-034 x0: RegWriteW=1, RdW=0, ALUResultW=0xFFFF, A1=0 -> RD1=0 in that cycle and the next; WbCount unchanged.
REQ-035 Reset priority and counter wrap: write x9=0x1234 with rst=1 -> x9 reads 0, WbCount=0; separately, 2^32 committed writes -> WbCount=0.
